pc_sequencer: RTL and testbench

//  Instruction-cycle controller for the picoMIPS core. Drives the program counter
//  (increment or relative-branch load), instruction-register capture, register-file

---
 rtl/pc_sequencer.sv | 156 +++++++++++++++
 tb/tb_pc_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Instruction-cycle controller for the picoMIPS core. It sequences FETCH/EXEC and
//   the switch-input handshake, steers the PC (increment or relative branch load),
//   strobes IR capture and the register-file write enable, and counts retired
//   instructions with a saturating counter.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   FETCH   | capture instruction into IR
//   EXEC    | act on decoded opcode, advance or branch the PC
//   WAIT    | IN instruction: wait for inReady, then write + ack
//   RELEASE | IN instruction: wait for inReady to drop (one input/press)
//   HALT    | core stopped, only reset leaves
//
// Ports
//   clk_i        system clock
//   nRst_i       synchronous active-low reset; forces every output low while asserted
//   opcode_i     decoded opcode of the current IR
//   brOffset_i   two's-complement branch offset
//   pcIn_i       current program counter
//   flagZ_i      ALU zero flag
//   inReady_i    external input-valid level
//   irLoad_o     capture instruction into IR
//   pcInc_o      increment PC
//   pcLoad_o     load pcTarget_o into PC
//   pcTarget_o   branch target (pcIn + brOffset, wrapping); driven only with pcLoad_o
//   regWe_o      register-file write enable
//   inAck_o      input accepted
//   halted_o     core stopped on HALT
//   retired_o    retired-instruction count, saturating

module pc_sequencer #(
    parameter int P_SIZE = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              nRst_i,
    input  logic [2:0]        opcode_i,
    input  logic [P_SIZE-1:0] brOffset_i,
    input  logic [P_SIZE-1:0] pcIn_i,
    input  logic              flagZ_i,
    input  logic              inReady_i,
    output logic              irLoad_o,
    output logic              pcInc_o,
    output logic              pcLoad_o,
    output logic [P_SIZE-1:0] pcTarget_o,
    output logic              regWe_o,
    output logic              inAck_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  retired_o
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_EXEC    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_HALT    = 3'd4;

    localparam logic [2:0] OP_ALU  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_BEQ  = 3'd2;
    localparam logic [2:0] OP_BNE  = 3'd3;
    localparam logic [2:0] OP_JMP  = 3'd4;
    localparam logic [2:0] OP_IN   = 3'd5;
    localparam logic [2:0] OP_NOP  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             ir_load, pc_inc, pc_load, reg_we, in_ack, halt_entry;

    always_comb begin
        state_d    = state_q;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        reg_we     = 1'b0;
        in_ack     = 1'b0;
        halt_entry = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_load = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode_i)
                    OP_ALU, OP_ADDI: begin
                        reg_we = 1'b1;
                        pc_inc = 1'b1;
                    end
                    OP_NOP:  pc_inc = 1'b1;
                    OP_BEQ: begin
                        pc_load = flagZ_i;
                        pc_inc  = ~flagZ_i;
                    end
                    OP_BNE: begin
                        pc_load = ~flagZ_i;
                        pc_inc  = flagZ_i;
                    end
                    OP_JMP:  pc_load = 1'b1;
                    OP_IN:   state_d = S_WAIT;
                    OP_HALT: begin
                        state_d    = S_HALT;
                        halt_entry = 1'b1;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_WAIT: begin
                if (inReady_i) begin
                    reg_we  = 1'b1;
                    in_ack  = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!inReady_i) state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // HALT entry counts as retiring the HALT instruction itself.
    always_comb begin
        retired_d = retired_q;
        if ((pc_inc || pc_load || halt_entry) && (retired_q != {CNT_W{1'b1}}))
            retired_d = retired_q + CNT_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (!nRst_i) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Outputs are qualified by nRst_i so an in-flight instruction has no effect
    // during the reset cycle itself.
    assign irLoad_o   = nRst_i & ir_load;
    assign pcInc_o    = nRst_i & pc_inc;
    assign pcLoad_o   = nRst_i & pc_load;
    assign regWe_o    = nRst_i & reg_we;
    assign inAck_o    = nRst_i & in_ack;
    assign halted_o   = nRst_i & (state_q == S_HALT);
    assign pcTarget_o = (nRst_i & pc_load) ? (pcIn_i + brOffset_i) : '0;
    assign retired_o  = nRst_i ? retired_q : '0;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       nRst;
    logic [2:0] opcode;
    logic [5:0] brOffset, pcIn;
    logic       flagZ, inReady;

    logic       irLoad, pcInc, pcLoad, regWe, inAck, halted;
    logic [5:0] pcTarget;
    logic [15:0] retired;

    logic       irLoad2, pcInc2, pcLoad2, regWe2, inAck2, halted2;
    logic [5:0] pcTarget2;
    logic [1:0] retired2;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic       ir;
        logic       inc;
        logic       load;
        logic       we;
        logic       ack;
        logic [5:0] tgt;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [2:0] OP_ALU = 3'd0, OP_ADDI = 3'd1, OP_BEQ = 3'd2, OP_BNE = 3'd3,
                           OP_JMP = 3'd4, OP_IN = 3'd5, OP_NOP = 3'd6, OP_HALT = 3'd7;

    always #5 clk = ~clk;

    pc_sequencer #(.P_SIZE(6), .CNT_W(16)) dut (
        .clk_i(clk), .nRst_i(nRst), .opcode_i(opcode), .brOffset_i(brOffset),
        .pcIn_i(pcIn), .flagZ_i(flagZ), .inReady_i(inReady),
        .irLoad_o(irLoad), .pcInc_o(pcInc), .pcLoad_o(pcLoad), .pcTarget_o(pcTarget),
        .regWe_o(regWe), .inAck_o(inAck), .halted_o(halted), .retired_o(retired)
    );

    pc_sequencer #(.P_SIZE(6), .CNT_W(2)) dut_sat (
        .clk_i(clk), .nRst_i(nRst), .opcode_i(opcode), .brOffset_i(brOffset),
        .pcIn_i(pcIn), .flagZ_i(flagZ), .inReady_i(inReady),
        .irLoad_o(irLoad2), .pcInc_o(pcInc2), .pcLoad_o(pcLoad2), .pcTarget_o(pcTarget2),
        .regWe_o(regWe2), .inAck_o(inAck2), .halted_o(halted2), .retired_o(retired2)
    );

    // Monitor: every cycle with any strobe active must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (irLoad || pcInc || pcLoad || regWe || inAck) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe t=%0t got ir=%b inc=%b load=%b we=%b ack=%b, none expected",
                         $time, irLoad, pcInc, pcLoad, regWe, inAck);
            end else begin
                e = exp_q.pop_front();
                if ({irLoad, pcInc, pcLoad, regWe, inAck} != {e.ir, e.inc, e.load, e.we, e.ack} ||
                    (e.load && pcTarget != e.tgt)) begin
                    miscompares++;
                    $display("FAIL strobe t=%0t got ir=%b inc=%b load=%b we=%b ack=%b tgt=%0d, expected ir=%b inc=%b load=%b we=%b ack=%b tgt=%0d",
                             $time, irLoad, pcInc, pcLoad, regWe, inAck, pcTarget,
                             e.ir, e.inc, e.load, e.we, e.ack, e.tgt);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic ir, input logic inc, input logic load,
                        input logic we, input logic ack, input logic [5:0] tgt);
        exp_t e;
        e = '{ir: ir, inc: inc, load: load, we: we, ack: ack, tgt: tgt};
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, act, expv);
        end
    endtask

    // One FETCH+EXEC instruction with its hand-computed EXEC strobes.
    task automatic run_instr(input logic [2:0] op, input logic [5:0] pc, input logic [5:0] off,
                             input logic z, input logic inc, input logic load,
                             input logic we, input logic [5:0] tgt);
        opcode   = op;
        pcIn     = pc;
        brOffset = off;
        flagZ    = z;
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        step();
        if (inc || load || we) push(1'b0, inc, load, we, 1'b0, tgt);
        step();
    endtask

    initial begin
        nRst = 1'b0; opcode = OP_NOP; brOffset = '0; pcIn = '0; flagZ = 1'b0; inReady = 1'b0;
        step();
        step();
        chk("reset_retired", 32'(retired), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        nRst = 1'b1;

        // Retire one NOP, then reset in the middle of an ALU EXEC.
        run_instr(OP_NOP, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
        chk("retired_before_reset", 32'(retired), 32'd1);
        opcode = OP_ALU;
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        step();
        nRst = 1'b0;
        #1;
        chk("midexec_reset_outputs", 32'({irLoad, pcInc, pcLoad, regWe, inAck, halted}), 32'd0);
        step();
        step();
        chk("midexec_reset_retired", 32'(retired), 32'd0);
        nRst = 1'b1;
        #1;
        chk("after_reset_fetch", 32'(irLoad), 32'd1);

        // ALU, NOP, ADDI
        run_instr(OP_ALU,  6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0);
        run_instr(OP_NOP,  6'd1, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        run_instr(OP_ADDI, 6'd2, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0);
        chk("retired_after_3", 32'(retired), 32'd3);

        // BEQ taken with wrap, then not taken
        run_instr(OP_BEQ, 6'd62, 6'd3, 1'b1, 1'b0, 1'b1, 1'b0, 6'd1);
        run_instr(OP_BEQ, 6'd62, 6'd3, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
        chk("retired_after_5", 32'(retired), 32'd5);
        chk("sat_retired_cntw2", 32'(retired2), 32'd3);

        // BNE taken backwards, then not taken; JMP regardless of flagZ
        run_instr(OP_BNE, 6'd10, 6'b111110, 1'b0, 1'b0, 1'b1, 1'b0, 6'd8);
        run_instr(OP_BNE, 6'd10, 6'b111110, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        run_instr(OP_JMP, 6'd5, 6'd4, 1'b0, 1'b0, 1'b1, 1'b0, 6'd9);
        run_instr(OP_JMP, 6'd5, 6'd4, 1'b1, 1'b0, 1'b1, 1'b0, 6'd9);
        chk("retired_after_9", 32'(retired), 32'd9);

        // IN: low for 5 WAIT cycles, high for 3, then drop
        opcode = OP_IN;
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        step();
        step();
        for (int i = 0; i < 5; i++) step();
        chk("in_wait_no_retire", 32'(retired), 32'd9);
        inReady = 1'b1;
        push(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd0);
        step();
        step();
        step();
        inReady = 1'b0;
        step();
        chk("retired_after_in", 32'(retired), 32'd10);
        run_instr(OP_NOP, 6'd20, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);

        // HALT
        opcode = OP_HALT;
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        step();
        chk("halt_exec_not_halted", 32'(halted), 32'd0);
        step();
        opcode  = OP_ALU;
        inReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("halted_level", 32'(halted), 32'd1);
            chk("halted_retired_frozen", 32'(retired), 32'd12);
            step();
        end
        chk("sat_retired_final", 32'(retired2), 32'd3);
        chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
